// File: rtl/usb_fs_pkg.sv
// usb_fs_pkg: shared FSM encoding and sizing constants for the USB FS buffer arbiters
package usb_fs_pkg;
  typedef enum logic {ARB_IDLE, ARB_GRANTED} arb_state_t;
  localparam int BYTE_W = 8;
  localparam int MAX_PKT_DEF = 64;
endpackage

// File: rtl/usb_fs_rr_pick.sv
// usb_fs_rr_pick: combinational round-robin finder of the first set request at or after ptr
module usb_fs_rr_pick #(
  parameter int N = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);
  int best, d;
  assign valid = |req;
  always_comb begin
    idx = '0;
    best = N;
    d = 0;
    for (int i = 0; i < N; i++) begin
      d = i >= int'(ptr) ? i - int'(ptr) : i + N - int'(ptr);
      if (req[i] && d < best) begin
        best = d;
        idx = IDX_W'(i);
      end
    end
    pick = valid ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/usb_fs_in_arb.sv
// usb_fs_in_arb: locks one IN endpoint onto the shared IN packet buffer and counts its bytes
module usb_fs_in_arb
  import usb_fs_pkg::*;
#(
  parameter int NUM_IN_EPS = 1,
  parameter int MAX_PKT = MAX_PKT_DEF,
  parameter int IDX_W = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_IN_EPS-1:0]        in_ep_req,
  output logic [NUM_IN_EPS-1:0]        in_ep_grant,
  input  logic [NUM_IN_EPS-1:0]        in_ep_data_put,
  input  logic [BYTE_W*NUM_IN_EPS-1:0] in_ep_data,
  input  logic [NUM_IN_EPS-1:0]        in_ep_data_done,
  output logic                         arb_data_put,
  output logic [BYTE_W-1:0]            arb_data,
  output logic                         arb_data_done,
  output logic [IDX_W-1:0]             arb_ep_idx,
  output logic                         arb_busy,
  output logic [6:0]                   arb_byte_cnt,
  output logic                         arb_overflow
);
  arb_state_t state;
  logic [IDX_W-1:0] rr_ptr, pick_idx;
  logic [NUM_IN_EPS-1:0] pick;
  logic pick_valid, sel_req, sel_put, sel_done, room;
  logic [BYTE_W-1:0] sel_data;
  usb_fs_rr_pick #(.N(NUM_IN_EPS), .IDX_W(IDX_W)) u_pick (
    .req(in_ep_req),
    .ptr(rr_ptr),
    .pick(pick),
    .idx(pick_idx),
    .valid(pick_valid)
  );
  always_comb begin
    sel_req = 1'b0;
    sel_put = 1'b0;
    sel_done = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_IN_EPS; i++)
      if (arb_ep_idx == IDX_W'(i)) begin
        sel_req = in_ep_req[i];
        sel_put = in_ep_data_put[i];
        sel_done = in_ep_data_done[i];
        sel_data = in_ep_data[BYTE_W*i +: BYTE_W];
      end
  end
  assign room = arb_byte_cnt < 7'(MAX_PKT);
  assign arb_data_put = arb_busy & sel_put & room;
  assign arb_data_done = arb_busy & sel_done;
  assign arb_data = arb_busy ? sel_data : '0;
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= ARB_IDLE;
      in_ep_grant <= '0;
      arb_ep_idx <= '0;
      arb_busy <= 1'b0;
      arb_byte_cnt <= '0;
      arb_overflow <= 1'b0;
      rr_ptr <= '0;
    end else begin
      arb_overflow <= arb_busy & sel_put & ~room;
      case (state)
        ARB_IDLE:
          if (pick_valid) begin
            state <= ARB_GRANTED;
            in_ep_grant <= pick;
            arb_ep_idx <= pick_idx;
            arb_busy <= 1'b1;
            arb_byte_cnt <= '0;
          end
        ARB_GRANTED: begin
          arb_byte_cnt <= sel_done ? '0 : arb_byte_cnt + 7'(arb_data_put);
          if (!sel_req) begin
            state <= ARB_IDLE;
            in_ep_grant <= '0;
            arb_busy <= 1'b0;
            arb_byte_cnt <= '0;
            rr_ptr <= arb_ep_idx == IDX_W'(NUM_IN_EPS - 1) ? '0 : arb_ep_idx + 1'b1;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_usb_fs_in_arb.sv
// tb_usb_fs_in_arb: directed literal checks plus random traffic against an owner/pointer model
module tb_usb_fs_in_arb;
  localparam int N = 4;
  localparam int MAXP = 64;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req = '0, grant, put = '0, done = '0;
  logic [8*N-1:0] data = '0;
  logic a_put, a_done, busy, ovf;
  logic [7:0] a_data;
  logic [3:0] idx;
  logic [6:0] cnt;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  int m_owner = -1, m_ptr = 0, m_cnt = 0;
  bit m_ovf = 0;

  usb_fs_in_arb #(.NUM_IN_EPS(N), .MAX_PKT(MAXP), .IDX_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_ep_req(req), .in_ep_grant(grant),
    .in_ep_data_put(put), .in_ep_data(data), .in_ep_data_done(done),
    .arb_data_put(a_put), .arb_data(a_data), .arb_data_done(a_done),
    .arb_ep_idx(idx), .arb_busy(busy), .arb_byte_cnt(cnt), .arb_overflow(ovf)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // model: one owner at a time, chosen as the nearest requester from the pointer
  always @(posedge clk) begin
    if (!reset_n) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_ovf = 0;
    end else if (m_owner < 0) begin
      m_ovf = 0;
      for (int k = N - 1; k >= 0; k--)
        if (req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      m_cnt = 0;
    end else begin
      m_ovf = put[m_owner] && m_cnt >= MAXP;
      if (done[m_owner]) m_cnt = 0;
      else if (put[m_owner] && m_cnt < MAXP) m_cnt = m_cnt + 1;
      if (!req[m_owner]) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  end

  always @(negedge clk)
    if (chk_en) begin
      cmp("m_busy", busy, m_owner >= 0);
      cmp("m_grant", grant, m_owner >= 0 ? 1 << m_owner : 0);
      cmp("m_ovf", ovf, m_ovf);
      if (m_owner >= 0) begin
        cmp("m_idx", idx, m_owner);
        cmp("m_cnt", cnt, m_cnt);
        cmp("m_put", a_put, put[m_owner] && m_cnt < MAXP);
        cmp("m_done", a_done, done[m_owner]);
        cmp("m_data", a_data, data[8*m_owner +: 8]);
      end else begin
        cmp("m_put_idle", a_put, 0);
        cmp("m_done_idle", a_done, 0);
      end
    end

  initial begin
    int w, n;
    tick(); tick();
    chk_en = 1;
    cmp("rst_grant", grant, 0); cmp("rst_busy", busy, 0); cmp("rst_idx", idx, 0);
    cmp("rst_cnt", cnt, 0); cmp("rst_ovf", ovf, 0);
    reset_n = 1; req = 4'b0100;
    tick();
    cmp("g_grant", grant, 4'b0100); cmp("g_idx", idx, 2); cmp("g_busy", busy, 1); cmp("g_cnt", cnt, 0);
    reset_n = 0;
    tick();
    cmp("mr_grant", grant, 0); cmp("mr_busy", busy, 0);
    reset_n = 1; req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (!busy && n < 8) begin tick(); n++; end
      cmp("rr_wait", busy, 1);
      cmp("rr_order", idx, g % 4);
      w = idx;
      tick(); tick();
      req[w] = 1'b0;
      tick();
      cmp("rr_gap", busy, 0);
      req[w] = 1'b1;
    end
    req = 4'b0000;
    tick(); tick();
    req = 4'b0010;
    tick();
    cmp("lk_grant", grant, 4'b0010);
    req = 4'b0011;
    for (int i = 0; i < 3; i++) begin tick(); cmp("lk_hold", grant, 4'b0010); end
    req = 4'b1101;
    tick();
    cmp("lk_rel", busy, 0);
    tick();
    cmp("lk_next", grant, 4'b0100); cmp("lk_idx", idx, 2);
    req = 4'b0000;
    tick();
    req = 4'b0010;
    tick();
    cmp("mx_grant", grant, 4'b0010);
    put = 4'b0011; data = 32'h0000_55AA;
    #1 cmp("mx_data", a_data, 8'h55); cmp("mx_put", a_put, 1);
    tick();
    put = 4'b0001; done = 4'b0001;
    #1 cmp("mx_put0", a_put, 0); cmp("mx_done0", a_done, 0);
    tick();
    put = 0; done = 4'b0010;
    tick();
    done = 0;
    cmp("of_clr", cnt, 0);
    for (int i = 0; i < 65; i++) begin
      put = 4'b0010; data = $urandom;
      #1 cmp("of_put", a_put, i < 64);
      if (i == 64) cmp("of_full", cnt, 64);
      tick();
    end
    cmp("of_pulse", ovf, 1); cmp("of_sat", cnt, 64);
    put = 0;
    tick();
    cmp("of_pulse_end", ovf, 0);
    done = 4'b0010;
    tick();
    done = 0;
    cmp("of_done", cnt, 0);
    put = 4'b0010;
    #1 cmp("of_reput", a_put, 1);
    tick();
    put = 0;
    cmp("of_cnt1", cnt, 1);
    done = 4'b0010;
    tick();
    done = 0;
    for (int i = 0; i < 10; i++) begin put = 4'b0010; tick(); end
    put = 0;
    cmp("pd_cnt10", cnt, 10);
    put = 4'b0010; done = 4'b0010; req = 4'b0000;
    #1 cmp("pd_put", a_put, 1); cmp("pd_done", a_done, 1);
    tick();
    put = 0; done = 0;
    cmp("pd_idle", busy, 0); cmp("pd_grant", grant, 0); cmp("pd_cnt", cnt, 0);
    for (int c = 0; c < 4000; c++) begin
      reset_n = $urandom_range(0, 299) != 0;
      for (int e = 0; e < N; e++) begin
        if ($urandom_range(0, 7) == 0) req[e] = ~req[e];
        put[e] = $urandom_range(0, 3) != 0;
        done[e] = $urandom_range(0, 59) == 0;
      end
      data = $urandom;
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
